bcd_calc_engine: RTL

- Parametrised successor to the fixed 2-digit keypad FSM plus combinational arithmetic path.
- Accepts scanned keypad codes and builds two DIGITS-wide BCD operands and an operator.
- On '=', runs a multi-cycle sequential calculation: BCD->binary (Horner), operate, then binary->BCD (double dabble).
- Sits between keypad_scan and the FTSD decode/control path; result is BCD-ready, so no separate converter is needed.

---
 rtl/bcd_calc_engine.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_calc_engine.sv
// Keypad-driven BCD calculator: builds two DIGITS-wide operands, then runs a Horner/op/double-dabble sequence.
// Key effects land one edge after the press edge; busy lasts DIGITS+1+4*RES_DIGITS cycles (CALC_DIV_EN adds divide).
module bcd_calc_engine #(
  parameter int DIGITS     = 2,
  parameter int RES_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              key,
  input  logic                    pressed,
  output logic [4*DIGITS-1:0]     num_a,
  output logic [4*DIGITS-1:0]     num_b,
  output logic [1:0]              op,
  output logic [4*RES_DIGITS-1:0] result,
  output logic                    result_neg,
  output logic                    overflow,
  output logic                    busy,
  output logic [1:0]              state
);
  localparam int BW   = 4*DIGITS;
  localparam int MW   = 8*DIGITS;
  localparam int RW   = 4*RES_DIGITS;
  localparam int CW   = (MW > RW) ? MW : RW;
  localparam int CNTW = $clog2(DIGITS+1);
  localparam int SW   = $clog2(RW+BW+1);

  function automatic logic [CW-1:0] max_result();
    logic [CW-1:0] v;
    v = CW'(1);
    for (int i = 0; i < RES_DIGITS; i++) v = CW'(v * CW'(10));
    return v - CW'(1);
  endfunction
  localparam logic [CW-1:0] LIMIT = max_result();

  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_CALC = 2'd2, S_RES = 2'd3} state_t;
  typedef enum logic [1:0] {P_LOAD = 2'd0, P_OP = 2'd1, P_DABBLE = 2'd2} phase_t;

  state_t          st;
  phase_t          phase;
  logic [SW-1:0]   step;
  logic            pressed_q;
  logic [CNTW-1:0] cnt_a, cnt_b;
  logic [BW-1:0]   sh_a, sh_b, bin_a, bin_b;
  logic [RW-1:0]   dd_bin, dd_bcd, dd_adj;
  logic [2*RW-1:0] dd_nx;
  logic            ovf_pend, neg_pend;
  logic [MW-1:0]   mag;
  logic            mag_neg, op_ovf;
  logic            key_evt, is_digit, is_op, is_bksp, is_eq, is_clr;
  logic [1:0]      op_code;

  assign state    = st;
  assign key_evt  = pressed & ~pressed_q;
  assign is_digit = key <= 4'd9;
  assign is_clr   = key == 4'd13;
  assign is_eq    = key == 4'd15;
  assign op_code  = (key == 4'd14) ? 2'd3 : 2'(key - 4'd10);
`ifdef CALC_DIV_EN
  assign is_op    = (key >= 4'd10 && key <= 4'd12) || key == 4'd14;
  assign is_bksp  = 1'b0;

  logic [BW-1:0] rem, rem_nx, quo_nx;
  logic [BW:0]   rem_sh;
  logic          div_ge;
  // One restoring-division step per cycle; bin_a doubles as the dividend/quotient shifter.
  always_comb begin
    rem_sh = {rem, bin_a[BW-1]};
    div_ge = rem_sh >= {1'b0, bin_b};
    rem_nx = BW'(div_ge ? rem_sh - {1'b0, bin_b} : rem_sh);
    quo_nx = {bin_a[BW-2:0], div_ge};
  end
`else
  assign is_op    = key >= 4'd10 && key <= 4'd12;
  assign is_bksp  = key == 4'd14;
`endif

  always_comb begin
    mag     = '0;
    mag_neg = 1'b0;
    case (op)
      2'd0: mag = MW'(bin_a) + MW'(bin_b);
      2'd1: begin
        mag_neg = bin_a < bin_b;
        mag     = mag_neg ? MW'(bin_b - bin_a) : MW'(bin_a - bin_b);
      end
      2'd2: mag = MW'(bin_a) * MW'(bin_b);
`ifdef CALC_DIV_EN
      default: mag = MW'(quo_nx);
`else
      default: mag = '0;
`endif
    endcase
`ifdef CALC_DIV_EN
    op_ovf = (CW'(mag) > LIMIT) || (op == 2'd3 && bin_b == '0);
`else
    op_ovf = CW'(mag) > LIMIT;
`endif
  end

  always_comb begin
    dd_adj = dd_bcd;
    for (int i = 0; i < RES_DIGITS; i++)
      if (dd_bcd[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd_bcd[4*i +: 4] + 4'd3;
    dd_nx = {dd_adj[RW-2:0], dd_bin, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_A;        phase <= P_LOAD;   step <= '0;
      pressed_q <= 1'b0; cnt_a <= '0;      cnt_b <= '0;
      num_a <= '0;      num_b <= '0;       op <= '0;
      result <= '0;     result_neg <= 1'b0; overflow <= 1'b0; busy <= 1'b0;
      sh_a <= '0;       sh_b <= '0;        bin_a <= '0;  bin_b <= '0;
      dd_bin <= '0;     dd_bcd <= '0;      ovf_pend <= 1'b0; neg_pend <= 1'b0;
`ifdef CALC_DIV_EN
      rem <= '0;
`endif
    end else begin
      pressed_q <= pressed;
      if (key_evt && is_clr) begin
        num_a <= '0;  num_b <= '0;  op <= '0;  result <= '0;
        result_neg <= 1'b0;  overflow <= 1'b0;  busy <= 1'b0;
        cnt_a <= '0;  cnt_b <= '0;  st <= S_A;
      end else begin
        case (st)
          S_A: if (key_evt) begin
            if (is_digit) begin
              if (cnt_a != CNTW'(DIGITS)) begin
                num_a <= BW'({num_a, key});
                cnt_a <= cnt_a + 1'b1;
              end
            end else if (is_bksp) begin
              if (cnt_a != '0) begin
                num_a <= num_a >> 4;
                cnt_a <= cnt_a - 1'b1;
              end
            end else if (is_op) begin
              op <= op_code;
              st <= S_B;
            end
          end
          S_B: if (key_evt) begin
            if (is_digit) begin
              if (cnt_b != CNTW'(DIGITS)) begin
                num_b <= BW'({num_b, key});
                cnt_b <= cnt_b + 1'b1;
              end
            end else if (is_bksp) begin
              if (cnt_b != '0) begin
                num_b <= num_b >> 4;
                cnt_b <= cnt_b - 1'b1;
              end
            end else if (is_op) begin
              if (cnt_b == '0) op <= op_code;
            end else if (is_eq && cnt_b != '0) begin
              st <= S_CALC;  busy <= 1'b1;  phase <= P_LOAD;  step <= '0;
              sh_a <= num_a; sh_b <= num_b; bin_a <= '0;     bin_b <= '0;
`ifdef CALC_DIV_EN
              rem <= '0;
`endif
            end
          end
          S_CALC: case (phase)
            P_LOAD: begin
              bin_a <= (bin_a << 3) + (bin_a << 1) + BW'(sh_a[BW-1 -: 4]);
              bin_b <= (bin_b << 3) + (bin_b << 1) + BW'(sh_b[BW-1 -: 4]);
              sh_a  <= sh_a << 4;
              sh_b  <= sh_b << 4;
              if (step == SW'(DIGITS-1)) begin
                phase <= P_OP;
                step  <= '0;
              end else begin
                step <= step + 1'b1;
              end
            end
            P_OP: begin
`ifdef CALC_DIV_EN
              if (op == 2'd3 && step != SW'(BW-1)) begin
                bin_a <= quo_nx;
                rem   <= rem_nx;
                step  <= step + 1'b1;
              end else
`endif
              begin
                // Overflow zeroes the dabble input so the fixed-length conversion still runs.
                ovf_pend <= op_ovf;
                neg_pend <= mag_neg & ~op_ovf;
                dd_bin   <= op_ovf ? '0 : RW'(mag);
                dd_bcd   <= '0;
                phase    <= P_DABBLE;
                step     <= '0;
              end
            end
            P_DABBLE: begin
              dd_bcd <= dd_nx[2*RW-1:RW];
              dd_bin <= dd_nx[RW-1:0];
              if (step == SW'(RW-1)) begin
                result     <= ovf_pend ? '0 : dd_nx[2*RW-1:RW];
                result_neg <= neg_pend;
                overflow   <= ovf_pend;
                busy       <= 1'b0;
                st         <= S_RES;
              end else begin
                step <= step + 1'b1;
              end
            end
            default: phase <= P_LOAD;
          endcase
          S_RES: if (key_evt && is_digit) begin
            num_a <= BW'(key);  cnt_a <= CNTW'(1);
            num_b <= '0;        cnt_b <= '0;
            result <= '0;       result_neg <= 1'b0;  overflow <= 1'b0;
            op <= '0;           st <= S_A;
          end
          default: st <= S_A;
        endcase
      end
    end
  end
endmodule
